// File: rtl/com8250_pkg.sv
// Shared 8250 register map constants and the RISC-V side register selector
// used by the COM-port transmit bridge.
package com8250_pkg;

  localparam logic [2:0] OFF_THR = 3'd0;
  localparam logic [2:0] OFF_IER = 3'd1;
  localparam logic [2:0] OFF_IIR = 3'd2;
  localparam logic [2:0] OFF_LCR = 3'd3;
  localparam logic [2:0] OFF_MCR = 3'd4;
  localparam logic [2:0] OFF_LSR = 3'd5;
  localparam logic [2:0] OFF_MSR = 3'd6;
  localparam logic [2:0] OFF_SCR = 3'd7;

  localparam int LSR_THRE  = 5;
  localparam int LSR_TEMT  = 6;
  localparam int LCR_DLAB  = 7;
  localparam int IER_ETBEI = 1;
  localparam int MCR_OUT2  = 3;

  localparam logic [7:0] IIR_NONE = 8'hC1;
  localparam logic [7:0] IIR_THRE = 8'hC2;
  localparam logic [7:0] MSR_IDLE = 8'hB0;
  localparam logic [7:0] DLL_RST  = 8'h0C;

  typedef enum logic [1:0] {
    R_DATA   = 2'd0,
    R_STATUS = 2'd1,
    R_BASE   = 2'd2,
    R_NONE   = 2'd3
  } r_reg_e;

  function automatic logic [7:0] lsr_value(input logic temt, input logic thre);
    lsr_value = '0;
    lsr_value[LSR_TEMT] = temt;
    lsr_value[LSR_THRE] = thre;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO with flush; push when full and pop when empty are
// no-ops, and a push that meets a full FIFO is dropped even alongside a pop.
module byte_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  push,
  input  logic                  pop,
  input  logic [7:0]            din,
  output logic [7:0]            dout,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = 1;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;

  logic [DEPTH_LOG2-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [7:0]            mem_q [DEPTH];
  logic                  do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rp_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    if (flush) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
    end else begin
      if (do_push) wp_d = wp_q + PTR_ONE;
      if (do_pop)  rp_d = rp_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wp_q] <= din;
  end

endmodule

// File: rtl/serial_tx_bridge.sv
// Emulated 8250 transmit side: x86 CPU writes THR bytes into a FIFO that
// RISC-V firmware drains over the r_* peripheral bus.
module serial_tx_bridge
  import com8250_pkg::*;
#(
  parameter logic [11:0] BASE       = 12'h3F8,
  parameter int          DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [9:0]  r_addr,
  input  logic [31:0] r_din,
  output logic [31:0] r_dout,
  input  logic [3:0]  r_lane,
  input  logic        r_wr,
  input  logic        r_valid,
  output logic        r_ready,
  input  logic [11:0] port,
  output logic [7:0]  dout,
  input  logic [7:0]  din,
  input  logic        cpu_iordin,
  output logic        cpu_iordout,
  input  logic        cpu_iowrin,
  output logic        cpu_iowrout,
  output logic        irq4
);

  localparam logic [DEPTH_LOG2:0] CNT_ONE = 1;

  logic        cpu_iordout_q, cpu_iordout_d, cpu_iowrout_q, cpu_iowrout_d;
  logic        r_ready_q, r_ready_d;
  logic [31:0] r_dout_q, r_dout_d;
  logic [7:0]  dll_q, dll_d, dlm_q, dlm_d, lcr_q, lcr_d, scr_q, scr_d;
  logic [3:0]  ier_q, ier_d;
  logic [4:0]  mcr_q, mcr_d;
  logic        thre_q, thre_d, overrun_q, overrun_d, irq4_q, irq4_d;
  logic        thre_set, thre_clr;

  logic        hit, cpu_rd, cpu_wr, dlab, thr_wr;
  logic [2:0]  off;
  logic        r_req, rv_pop, status_rd, flush;
  r_reg_e      r_sel;

  logic [7:0]            fifo_dout;
  logic [DEPTH_LOG2:0]   fifo_count;
  logic                  fifo_full, fifo_empty;
  logic                  unused_ok;

  assign unused_ok = ^{r_lane, r_addr[9:4], r_addr[1:0], r_din[31:1]};

  assign hit    = (port[11:3] == BASE[11:3]);
  assign off    = port[2:0];
  assign cpu_rd = (cpu_iordin ^ cpu_iordout_q) & hit;
  assign cpu_wr = (cpu_iowrin ^ cpu_iowrout_q) & hit;
  assign dlab   = lcr_q[LCR_DLAB];
  assign thr_wr = cpu_wr & (off == OFF_THR) & ~dlab;

  // RISC-V bus: a request is r_valid while r_ready is low; it is acted on in
  // that cycle and acknowledged with r_ready (and r_dout) for exactly one cycle.
  assign r_sel     = r_reg_e'(r_addr[3:2]);
  assign r_req     = r_valid & ~r_ready_q;
  assign rv_pop    = r_req & ~r_wr & (r_sel == R_DATA);
  assign status_rd = r_req & ~r_wr & (r_sel == R_STATUS);
  assign flush     = r_req & r_wr & (r_sel == R_STATUS) & r_din[0];

  byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk   (clk),
    .rst_n (reset_n),
    .flush (flush),
    .push  (thr_wr),
    .pop   (rv_pop),
    .din   (din),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    dll_d    = dll_q;
    dlm_d    = dlm_q;
    lcr_d    = lcr_q;
    scr_d    = scr_q;
    ier_d    = ier_q;
    mcr_d    = mcr_q;
    thre_set = 1'b0;
    if (cpu_wr) begin
      case (off)
        OFF_THR: if (dlab) dll_d = din;
        OFF_IER: begin
          if (dlab) begin
            dlm_d = din;
          end else begin
            ier_d = din[3:0];
            if (!ier_q[IER_ETBEI] && din[IER_ETBEI] && !fifo_full) thre_set = 1'b1;
          end
        end
        OFF_LCR: lcr_d = din;
        OFF_MCR: mcr_d = din[4:0];
        OFF_SCR: scr_d = din;
        default: ;
      endcase
    end
    // A lone pop of the last byte empties the FIFO; a same-cycle push keeps it occupied.
    if (flush || (rv_pop && fifo_count == CNT_ONE && !(thr_wr && !fifo_full)))
      thre_set = 1'b1;
    thre_clr  = thr_wr | (cpu_rd & (off == OFF_IIR));
    thre_d    = (thre_q | thre_set) & ~thre_clr;
    overrun_d = (overrun_q & ~status_rd) | (thr_wr & fifo_full);
    irq4_d    = ier_q[IER_ETBEI] & mcr_q[MCR_OUT2] & thre_q;
    cpu_iordout_d = cpu_iordin;
    cpu_iowrout_d = cpu_iowrin;
    r_ready_d     = r_req;
  end

  always_comb begin
    r_dout_d = '0;
    if (r_req && !r_wr) begin
      case (r_sel)
        R_DATA:   if (!fifo_empty) r_dout_d = {1'b1, 15'd0, 8'(fifo_count), fifo_dout};
        R_STATUS: r_dout_d = {29'd0, overrun_q, fifo_empty, fifo_full};
        R_BASE:   r_dout_d = {20'd0, BASE};
        default:  r_dout_d = '0;
      endcase
    end
  end

  always_comb begin
    dout = '0;
    case (off)
      OFF_THR: dout = dlab ? dll_q : 8'h00;
      OFF_IER: dout = dlab ? dlm_q : {4'b0, ier_q};
      OFF_IIR: dout = thre_q ? IIR_THRE : IIR_NONE;
      OFF_LCR: dout = lcr_q;
      OFF_MCR: dout = {3'b0, mcr_q};
      OFF_LSR: dout = lsr_value(fifo_empty, ~fifo_full);
      OFF_MSR: dout = MSR_IDLE;
      OFF_SCR: dout = scr_q;
      default: dout = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_iordout_q <= 1'b0;
      cpu_iowrout_q <= 1'b0;
      r_ready_q     <= 1'b0;
      r_dout_q      <= '0;
      dll_q         <= DLL_RST;
      dlm_q         <= '0;
      lcr_q         <= '0;
      scr_q         <= '0;
      ier_q         <= '0;
      mcr_q         <= '0;
      thre_q        <= 1'b0;
      overrun_q     <= 1'b0;
      irq4_q        <= 1'b0;
    end else begin
      cpu_iordout_q <= cpu_iordout_d;
      cpu_iowrout_q <= cpu_iowrout_d;
      r_ready_q     <= r_ready_d;
      r_dout_q      <= r_dout_d;
      dll_q         <= dll_d;
      dlm_q         <= dlm_d;
      lcr_q         <= lcr_d;
      scr_q         <= scr_d;
      ier_q         <= ier_d;
      mcr_q         <= mcr_d;
      thre_q        <= thre_d;
      overrun_q     <= overrun_d;
      irq4_q        <= irq4_d;
    end
  end

  assign cpu_iordout = cpu_iordout_q;
  assign cpu_iowrout = cpu_iowrout_q;
  assign r_ready     = r_ready_q;
  assign r_dout      = r_dout_q;
  assign irq4        = irq4_q;

endmodule

// File: tb/tb_serial_tx_bridge.sv
// Self-checking bench for serial_tx_bridge: directed scenarios plus a random
// push/pop/status mix against a queue-based model of the transmit FIFO.
module tb_serial_tx_bridge;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [9:0]  r_addr = '0;
  logic [31:0] r_din = '0;
  logic [31:0] r_dout;
  logic [3:0]  r_lane = 4'hF;
  logic        r_wr = 1'b0;
  logic        r_valid = 1'b0;
  logic        r_ready;
  logic [11:0] port = '0;
  logic [7:0]  dout;
  logic [7:0]  din = '0;
  logic        cpu_iordin = 1'b0;
  logic        cpu_iordout;
  logic        cpu_iowrin = 1'b0;
  logic        cpu_iowrout;
  logic        irq4;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];
  logic        exp_overrun = 1'b0;

  serial_tx_bridge dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .r_addr      (r_addr),
    .r_din       (r_din),
    .r_dout      (r_dout),
    .r_lane      (r_lane),
    .r_wr        (r_wr),
    .r_valid     (r_valid),
    .r_ready     (r_ready),
    .port        (port),
    .dout        (dout),
    .din         (din),
    .cpu_iordin  (cpu_iordin),
    .cpu_iordout (cpu_iordout),
    .cpu_iowrin  (cpu_iowrin),
    .cpu_iowrout (cpu_iowrout),
    .irq4        (irq4)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    #1;
    reset_n    = 1'b0;
    cpu_iordin = 1'b0;
    cpu_iowrin = 1'b0;
    r_valid    = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    exp_q.delete();
    exp_overrun = 1'b0;
    @(posedge clk); #1;
  endtask

  // ---------------- drivers ----------------
  task automatic cpu_write(input logic [11:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    port = a; din = d; cpu_iowrin = ~cpu_iowrin;
    @(posedge clk); #1;
  endtask

  task automatic cpu_read(input logic [11:0] a, output logic [7:0] d);
    @(posedge clk); #1;
    port = a; cpu_iordin = ~cpu_iordin;
    #1 d = dout;
    @(posedge clk); #1;
  endtask

  task automatic r_access(input logic [9:0] a, input logic wr, input logic [31:0] wd,
                          output logic [31:0] rd);
    logic ok;
    @(posedge clk); #1;
    r_addr = a; r_wr = wr; r_din = wd; r_valid = 1'b1;
    ok = 1'b0; rd = '0;
    for (int i = 0; i < 4 && !ok; i++) begin
      @(posedge clk); #1;
      if (r_ready) begin ok = 1'b1; rd = r_dout; end
    end
    r_valid = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL r_ack_timeout addr=%h got no r_ready want ack", a); end
  endtask

  // model helpers: expected words derived from the queue contents
  function automatic logic [31:0] exp_data_word();
    if (exp_q.size() == 0) return 32'h0;
    return {1'b1, 15'd0, 8'(exp_q.size()), exp_q[0]};
  endfunction

  function automatic logic [31:0] exp_status_word();
    return {29'd0, exp_overrun, exp_q.size() == 0, exp_q.size() == DEPTH};
  endfunction

  function automatic logic [7:0] exp_lsr();
    return {1'b0, exp_q.size() == 0, exp_q.size() < DEPTH, 5'b0};
  endfunction

  task automatic model_push(input logic [7:0] b);
    if (exp_q.size() == DEPTH) exp_overrun = 1'b1;
    else exp_q.push_back(b);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [7:0] rb;
    logic [31:0] w;
    checks++; if (r_ready !== 1'b0) begin errors++; $display("FAIL rst_r_ready got %b want 0", r_ready); end
    checks++; if (r_dout !== 32'h0) begin errors++; $display("FAIL rst_r_dout got %h want 0", r_dout); end
    checks++; if (irq4 !== 1'b0) begin errors++; $display("FAIL rst_irq4 got %b want 0", irq4); end
    checks++; if ({cpu_iordout, cpu_iowrout} !== 2'b00) begin errors++; $display("FAIL rst_acks got %b want 00", {cpu_iordout, cpu_iowrout}); end
    cpu_read(12'h3FD, rb);
    checks++; if (rb !== 8'h60) begin errors++; $display("FAIL rst_lsr got %h want 60", rb); end
    checks++; if (cpu_iordout !== cpu_iordin) begin errors++; $display("FAIL rd_ack got %b want %b", cpu_iordout, cpu_iordin); end
    cpu_read(12'h3FA, rb);
    checks++; if (rb !== 8'hC1) begin errors++; $display("FAIL rst_iir got %h want C1", rb); end
    cpu_read(12'h3FE, rb);
    checks++; if (rb !== 8'hB0) begin errors++; $display("FAIL msr got %h want B0", rb); end
    cpu_write(12'h3FB, 8'h80);
    checks++; if (cpu_iowrout !== cpu_iowrin) begin errors++; $display("FAIL wr_ack got %b want %b", cpu_iowrout, cpu_iowrin); end
    cpu_read(12'h3F8, rb);
    checks++; if (rb !== 8'h0C) begin errors++; $display("FAIL rst_dll got %h want 0C", rb); end
    cpu_write(12'h3FB, 8'h00);
    r_access(10'h008, 1'b0, 32'h0, w);
    checks++; if (w !== 32'h0000_03F8) begin errors++; $display("FAIL base_reg got %h want 000003F8", w); end
    // reset in the middle of operation
    for (int i = 0; i < 3; i++) cpu_write(12'h3F8, 8'(8'h41 + i));
    cpu_read(12'h3FD, rb);
    checks++; if (rb !== 8'h20) begin errors++; $display("FAIL mid_lsr_pre got %h want 20", rb); end
    do_reset();
    cpu_read(12'h3FD, rb);
    checks++; if (rb !== 8'h60) begin errors++; $display("FAIL mid_lsr_post got %h want 60", rb); end
    checks++; if (irq4 !== 1'b0) begin errors++; $display("FAIL mid_irq4 got %b want 0", irq4); end
    r_access(10'h000, 1'b0, 32'h0, w);
    checks++; if (w[31] !== 1'b0) begin errors++; $display("FAIL mid_data_valid got %b want 0", w[31]); end
  endtask

  task automatic test_write_drain();
    logic [7:0] rb;
    logic [31:0] w, e;
    cpu_write(12'h2F8, 8'h99);
    cpu_read(12'h3FD, rb);
    checks++; if (rb !== 8'h60) begin errors++; $display("FAIL miss_decode_lsr got %h want 60", rb); end
    for (int i = 0; i < 3; i++) begin
      cpu_write(12'h3F8, 8'(8'h41 + i));
      model_push(8'(8'h41 + i));
    end
    cpu_read(12'h3FD, rb);
    checks++; if (rb !== 8'h20) begin errors++; $display("FAIL wd_lsr got %h want 20", rb); end
    for (int i = 0; i < 4; i++) begin
      e = exp_data_word();
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      r_access(10'h000, 1'b0, 32'h0, w);
      checks++; if (w !== e) begin errors++; $display("FAIL wd_data%0d got %h want %h", i, w, e); end
    end
    cpu_read(12'h3FD, rb);
    checks++; if (rb !== 8'h60) begin errors++; $display("FAIL wd_lsr_end got %h want 60", rb); end
  endtask

  task automatic test_overflow();
    logic [7:0] rb;
    logic [31:0] w, e;
    for (int i = 1; i <= 17; i++) begin
      cpu_write(12'h3F8, 8'(i));
      model_push(8'(i));
    end
    cpu_read(12'h3FD, rb);
    checks++; if (rb !== 8'h00) begin errors++; $display("FAIL ov_lsr got %h want 00", rb); end
    for (int k = 0; k < 2; k++) begin
      e = exp_status_word();
      exp_overrun = 1'b0;
      r_access(10'h004, 1'b0, 32'h0, w);
      checks++; if (w !== e) begin errors++; $display("FAIL ov_status%0d got %h want %h", k, w, e); end
    end
    for (int i = 0; i < 17; i++) begin
      e = exp_data_word();
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      r_access(10'h000, 1'b0, 32'h0, w);
      checks++; if (w !== e) begin errors++; $display("FAIL ov_drain%0d got %h want %h", i, w, e); end
    end
  endtask

  task automatic test_irq();
    logic [7:0] rb;
    logic [31:0] w;
    logic ok;
    cpu_write(12'h3F9, 8'h02);
    cpu_write(12'h3FC, 8'h08);
    ok = 1'b0;
    for (int i = 0; i < 3 && !ok; i++) begin @(posedge clk); #1; if (irq4) ok = 1'b1; end
    checks++; if (!ok) begin errors++; $display("FAIL irq_assert got 0 want 1"); end
    cpu_read(12'h3FA, rb);
    checks++; if (rb !== 8'hC2) begin errors++; $display("FAIL irq_iir1 got %h want C2", rb); end
    cpu_read(12'h3FA, rb);
    checks++; if (rb !== 8'hC1) begin errors++; $display("FAIL irq_iir2 got %h want C1", rb); end
    ok = 1'b0;
    for (int i = 0; i < 3 && !ok; i++) begin @(posedge clk); #1; if (!irq4) ok = 1'b1; end
    checks++; if (!ok) begin errors++; $display("FAIL irq_deassert got 1 want 0"); end
    cpu_write(12'h3F8, 8'h55);
    repeat (2) @(posedge clk); #1;
    checks++; if (irq4 !== 1'b0) begin errors++; $display("FAIL irq_hold got %b want 0", irq4); end
    r_access(10'h000, 1'b0, 32'h0, w);
    checks++; if (w !== {1'b1, 15'd0, 8'd1, 8'h55}) begin errors++; $display("FAIL irq_pop got %h want 80000155", w); end
    ok = 1'b0;
    for (int i = 0; i < 3 && !ok; i++) begin @(posedge clk); #1; if (irq4) ok = 1'b1; end
    checks++; if (!ok) begin errors++; $display("FAIL irq_reassert got 0 want 1"); end
    cpu_read(12'h3FA, rb);
    cpu_write(12'h3F9, 8'h00);
    cpu_write(12'h3FC, 8'h00);
    repeat (2) @(posedge clk); #1;
    checks++; if (irq4 !== 1'b0) begin errors++; $display("FAIL irq_off got %b want 0", irq4); end
  endtask

  task automatic test_dlab();
    logic [7:0] rb;
    logic [31:0] w;
    cpu_write(12'h3FB, 8'h80);
    cpu_write(12'h3F8, 8'h01);
    cpu_write(12'h3F9, 8'h00);
    cpu_read(12'h3FD, rb);
    checks++; if (rb !== 8'h60) begin errors++; $display("FAIL dlab_lsr got %h want 60", rb); end
    cpu_read(12'h3F8, rb);
    checks++; if (rb !== 8'h01) begin errors++; $display("FAIL dlab_dll got %h want 01", rb); end
    cpu_read(12'h3F9, rb);
    checks++; if (rb !== 8'h00) begin errors++; $display("FAIL dlab_dlm got %h want 00", rb); end
    cpu_write(12'h3FB, 8'h03);
    cpu_read(12'h3F8, rb);
    checks++; if (rb !== 8'h00) begin errors++; $display("FAIL dlab_thr_rd got %h want 00", rb); end
    cpu_read(12'h3FB, rb);
    checks++; if (rb !== 8'h03) begin errors++; $display("FAIL lcr_rd got %h want 03", rb); end
    cpu_write(12'h3FF, 8'hA5);
    cpu_read(12'h3FF, rb);
    checks++; if (rb !== 8'hA5) begin errors++; $display("FAIL scr_rd got %h want A5", rb); end
    r_access(10'h000, 1'b0, 32'h0, w);
    checks++; if (w !== 32'h0) begin errors++; $display("FAIL dlab_fifo got %h want 0", w); end
  endtask

  task automatic test_collision();
    logic [31:0] w, e;
    logic [7:0] b;
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom_range(0, 255));
      cpu_write(12'h3F8, b);
      model_push(b);
    end
    e = exp_data_word();
    void'(exp_q.pop_front());
    exp_overrun = 1'b1;
    @(posedge clk); #1;
    port = 12'h3F8; din = 8'hEE; cpu_iowrin = ~cpu_iowrin;
    r_addr = 10'h000; r_wr = 1'b0; r_valid = 1'b1;
    @(posedge clk); #1;
    r_valid = 1'b0;
    checks++; if (r_ready !== 1'b1 || r_dout !== e) begin errors++; $display("FAIL col_pop got %b/%h want 1/%h", r_ready, r_dout, e); end
    e = exp_status_word();
    exp_overrun = 1'b0;
    r_access(10'h004, 1'b0, 32'h0, w);
    checks++; if (w !== e) begin errors++; $display("FAIL col_status got %h want %h", w, e); end
    for (int i = 0; i < DEPTH; i++) begin
      e = exp_data_word();
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      r_access(10'h000, 1'b0, 32'h0, w);
      checks++; if (w !== e) begin errors++; $display("FAIL col_drain%0d got %h want %h", i, w, e); end
    end
  endtask

  task automatic test_flush();
    logic [7:0] rb;
    logic [31:0] w, e;
    for (int i = 0; i < 3; i++) begin cpu_write(12'h3F8, 8'(8'h70 + i)); model_push(8'(8'h70 + i)); end
    r_access(10'h004, 1'b1, 32'h0000_0000, w);
    e = exp_status_word();
    r_access(10'h004, 1'b0, 32'h0, w);
    checks++; if (w !== e) begin errors++; $display("FAIL noflush_status got %h want %h", w, e); end
    cpu_read(12'h3FA, rb);
    checks++; if (rb !== 8'hC1) begin errors++; $display("FAIL preflush_iir got %h want C1", rb); end
    r_access(10'h004, 1'b1, 32'h0000_0001, w);
    exp_q.delete();
    cpu_read(12'h3FA, rb);
    checks++; if (rb !== 8'hC2) begin errors++; $display("FAIL flush_iir got %h want C2", rb); end
    e = exp_status_word();
    r_access(10'h004, 1'b0, 32'h0, w);
    checks++; if (w !== e) begin errors++; $display("FAIL flush_status got %h want %h", w, e); end
    r_access(10'h000, 1'b0, 32'h0, w);
    checks++; if (w !== 32'h0) begin errors++; $display("FAIL flush_data got %h want 0", w); end
  endtask

  task automatic test_random();
    logic [7:0] rb, b;
    logic [31:0] w, e;
    int op;
    for (int n = 0; n < 300; n++) begin
      op = $urandom_range(0, 9);
      if (op <= 4) begin
        b = 8'($urandom_range(0, 255));
        cpu_write(12'h3F8, b);
        model_push(b);
      end else if (op <= 7) begin
        e = exp_data_word();
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        r_access(10'h000, 1'b0, 32'h0, w);
        checks++; if (w !== e) begin errors++; $display("FAIL rnd_data n=%0d got %h want %h", n, w, e); end
      end else if (op == 8) begin
        e = exp_status_word();
        exp_overrun = 1'b0;
        r_access(10'h004, 1'b0, 32'h0, w);
        checks++; if (w !== e) begin errors++; $display("FAIL rnd_status n=%0d got %h want %h", n, w, e); end
      end else begin
        cpu_read(12'h3FD, rb);
        checks++; if (rb !== exp_lsr()) begin errors++; $display("FAIL rnd_lsr n=%0d got %h want %h", n, rb, exp_lsr()); end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    do_reset();
    test_reset();
    do_reset();
    test_write_drain();
    test_overflow();
    do_reset();
    test_irq();
    test_dlab();
    do_reset();
    test_collision();
    test_flush();
    do_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
